// File: rtl/compressor_if.sv
// -----------------------------------------------------------------------------
// compressor_if
// Handshake bundle between a word producer / line consumer and the compressor.
//   i_valid, i_word : upstream word, accepted when i_valid && o_ready
//   o_ready         : compressor can take a word this cycle
//   i_flush         : one-cycle request to emit the partial line, zero-padded
//   o_valid, o_data : packed output line, consumed when o_valid && i_ready
//   i_ready         : downstream accepts the line
//   o_last          : the line was produced by a flush
//   o_busy          : compressor holds unsent bits or a pending flush
// Modports: master = producer/consumer side, slave = compressor side.
// -----------------------------------------------------------------------------
interface compressor_if #(
  parameter int WIDTH          = 32,
  parameter int WIDTH_DATA_OUT = 128
);
  logic                      i_valid;
  logic [WIDTH-1:0]          i_word;
  logic                      o_ready;
  logic                      i_flush;
  logic                      o_valid;
  logic                      i_ready;
  logic [WIDTH_DATA_OUT-1:0] o_data;
  logic                      o_last;
  logic                      o_busy;

  modport master (
    output i_valid, i_word, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_busy
  );

  modport slave (
    input  i_valid, i_word, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_last, o_busy
  );
endinterface

// File: rtl/compressor.sv
// -----------------------------------------------------------------------------
// compressor
// Word-level dictionary compressor. Each accepted 32-bit word is matched against
// a 16-entry shift-FIFO dictionary and encoded as a 2..34-bit code, packed
// LSB-first into 128-bit output lines for the matching decompressor.
//   i_clk    : clock, rising edge
//   i_reset  : synchronous, active-high reset
//   bus      : compressor_if.slave (word input, line output, flush, status)
// -----------------------------------------------------------------------------
module compressor #(
  parameter int WIDTH          = 32,
  parameter int WORD           = 16,
  parameter int WIDTH_DATA_OUT = 128,
  parameter int LENGTH         = 6,
  parameter int FILL_WIDTH     = 8
) (
  input logic         i_clk,
  input logic         i_reset,
  compressor_if.slave bus
);
  localparam int CODE_W = WIDTH + 2;
  localparam int ACC_W  = WIDTH_DATA_OUT + CODE_W;
  localparam int IDX_W  = $clog2(WORD);
  localparam logic [FILL_WIDTH-1:0] LINE_BITS = FILL_WIDTH'(WIDTH_DATA_OUT);

  typedef enum logic [2:0] {
    K_ZZZZ,
    K_MMMM,
    K_ZZZX,
    K_MMMX,
    K_MMXX,
    K_XXXX
  } kind_t;

  logic [WIDTH-1:0]          r_dict [WORD];
  logic [ACC_W-1:0]          r_acc;
  logic [FILL_WIDTH-1:0]     r_fill;
  logic                      r_flush_pending;
  logic                      r_valid;
  logic                      r_last;
  logic [WIDTH_DATA_OUT-1:0] r_data;

  logic                      w_full_hit;
  logic                      w_hit24;
  logic                      w_hit16;
  logic [IDX_W-1:0]          w_full_idx;
  logic [IDX_W-1:0]          w_idx24;
  logic [IDX_W-1:0]          w_idx16;
  kind_t                     w_kind;
  logic [CODE_W-1:0]         w_code;
  logic [LENGTH-1:0]         w_len;
  logic                      w_push;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_out_free;
  logic                      w_pop;
  logic                      w_flush_done;
  logic                      w_flush_line;
  logic [ACC_W-1:0]          w_acc_base;
  logic [FILL_WIDTH-1:0]     w_fill_base;
  logic [ACC_W-1:0]          w_acc_next;
  logic [FILL_WIDTH-1:0]     w_fill_next;

  // Dictionary search on pre-push contents; first hit in index order wins.
  always_comb begin
    w_full_hit = 1'b0;
    w_hit24    = 1'b0;
    w_hit16    = 1'b0;
    w_full_idx = '0;
    w_idx24    = '0;
    w_idx16    = '0;
    for (int unsigned k = 0; k < WORD; k++) begin
      if (!w_full_hit && r_dict[k] == bus.i_word) begin
        w_full_hit = 1'b1;
        w_full_idx = IDX_W'(k);
      end
      if (!w_hit24 && r_dict[k][WIDTH-1:8] == bus.i_word[WIDTH-1:8]) begin
        w_hit24 = 1'b1;
        w_idx24 = IDX_W'(k);
      end
      if (!w_hit16 && r_dict[k][WIDTH-1:16] == bus.i_word[WIDTH-1:16]) begin
        w_hit16 = 1'b1;
        w_idx16 = IDX_W'(k);
      end
    end
  end

  // Code selection by priority; {backup, code} places the 2-bit code at [1:0].
  always_comb begin
    w_kind = K_XXXX;
    w_code = CODE_W'({bus.i_word, 2'b01});
    w_len  = LENGTH'(CODE_W);
    if (bus.i_word == '0) begin
      w_kind = K_ZZZZ;
      w_code = '0;
      w_len  = LENGTH'(2);
    end else if (w_full_hit) begin
      w_kind = K_MMMM;
      w_code = CODE_W'({w_full_idx, 2'b10});
      w_len  = LENGTH'(6);
    end else if (bus.i_word[WIDTH-1:8] == '0) begin
      w_kind = K_ZZZX;
      w_code = CODE_W'({bus.i_word[7:0], 2'b01, 2'b11});
      w_len  = LENGTH'(12);
    end else if (w_hit24) begin
      w_kind = K_MMMX;
      w_code = CODE_W'({bus.i_word[7:0], w_idx24, 2'b10, 2'b11});
      w_len  = LENGTH'(16);
    end else if (w_hit16) begin
      w_kind = K_MMXX;
      w_code = CODE_W'({bus.i_word[15:0], w_idx16, 2'b00, 2'b11});
      w_len  = LENGTH'(24);
    end
  end

  assign w_push = (w_kind == K_MMMX) || (w_kind == K_MMXX) || (w_kind == K_XXXX);

  assign w_ready      = (r_fill < LINE_BITS) && !r_flush_pending && !i_reset;
  assign w_accept     = bus.i_valid && w_ready;
  assign w_out_free   = !r_valid || bus.i_ready;
  assign w_pop        = (r_fill >= LINE_BITS) && w_out_free;
  // A pending flush blocks accepts, so it never coincides with an append.
  assign w_flush_done = r_flush_pending && (r_fill < LINE_BITS) && w_out_free;
  assign w_flush_line = w_flush_done && (r_fill != '0);

  // Pop is applied before append so a same-edge code lands after the remainder.
  always_comb begin
    w_acc_base  = w_pop ? (r_acc >> WIDTH_DATA_OUT) : r_acc;
    w_fill_base = w_pop ? (r_fill - LINE_BITS) : r_fill;
    w_acc_next  = w_acc_base;
    w_fill_next = w_fill_base;
    if (w_accept) begin
      w_acc_next  = w_acc_base | (ACC_W'(w_code) << w_fill_base);
      w_fill_next = w_fill_base + FILL_WIDTH'(w_len);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc           <= '0;
      r_fill          <= '0;
      r_flush_pending <= 1'b0;
      r_valid         <= 1'b0;
      r_last          <= 1'b0;
      r_data          <= '0;
      for (int unsigned k = 0; k < WORD; k++) begin
        r_dict[k] <= '0;
      end
    end else begin
      r_acc           <= w_flush_done ? '0 : w_acc_next;
      r_fill          <= w_flush_done ? '0 : w_fill_next;
      r_flush_pending <= bus.i_flush || (r_flush_pending && !w_flush_done);

      // Bits above fill are always zero, so the flush line is already padded.
      if (w_pop || w_flush_line) begin
        r_valid <= 1'b1;
        r_data  <= r_acc[WIDTH_DATA_OUT-1:0];
        r_last  <= w_flush_line;
      end else if (bus.i_ready) begin
        r_valid <= 1'b0;
      end

      if (w_accept && w_push) begin
        r_dict[0] <= bus.i_word;
        for (int unsigned k = 1; k < WORD; k++) begin
          r_dict[k] <= r_dict[k-1];
        end
      end
    end
  end

  assign bus.o_ready = w_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_last  = r_last;
  assign bus.o_busy  = (r_fill != '0) || r_flush_pending;
endmodule

// File: tb/tb_compressor.sv
// -----------------------------------------------------------------------------
// tb_compressor
// Self-checking bench for compressor. A reference model keeps the expected
// output bit stream in a queue and the dictionary as a queue (newest first);
// captured output lines are compared against 128-bit slices of that stream.
// -----------------------------------------------------------------------------
module tb_compressor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compressor_if #(.WIDTH(32), .WIDTH_DATA_OUT(128)) bus ();

  compressor #(
    .WIDTH(32),
    .WORD(16),
    .WIDTH_DATA_OUT(128),
    .LENGTH(6),
    .FILL_WIDTH(8)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit          exp_bits[$];
  logic [31:0] dict_q[$];
  logic [127:0] got_data[$];
  bit          got_last[$];

  // Capture every line the downstream side takes.
  always @(negedge clk) begin
    if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      got_data.push_back(bus.o_data);
      got_last.push_back(bus.o_last);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_bits.delete();
    dict_q.delete();
    for (int i = 0; i < 16; i++) dict_q.push_back(32'h0);
    got_data.delete();
    got_last.delete();
  endtask

  task automatic model_accept(input logic [31:0] w);
    int full_i, i24, i16, len;
    logic [33:0] code;
    logic [31:0] e;
    bit push;
    full_i = -1; i24 = -1; i16 = -1;
    for (int i = 0; i < 16; i++) begin
      e = dict_q[i];
      if (full_i < 0 && e == w) full_i = i;
      if (i24 < 0 && e[31:8] == w[31:8]) i24 = i;
      if (i16 < 0 && e[31:16] == w[31:16]) i16 = i;
    end
    push = 1'b0;
    if (w == 32'h0) begin
      code = 34'h0; len = 2;
    end else if (full_i >= 0) begin
      code = {28'h0, 4'(full_i), 2'b10}; len = 6;
    end else if (w[31:8] == 24'h0) begin
      code = {22'h0, w[7:0], 2'b01, 2'b11}; len = 12;
    end else if (i24 >= 0) begin
      code = {18'h0, w[7:0], 4'(i24), 2'b10, 2'b11}; len = 16; push = 1'b1;
    end else if (i16 >= 0) begin
      code = {10'h0, w[15:0], 4'(i16), 2'b00, 2'b11}; len = 24; push = 1'b1;
    end else begin
      code = {w, 2'b01}; len = 34; push = 1'b1;
    end
    for (int b = 0; b < len; b++) exp_bits.push_back(code[b]);
    if (push) begin
      dict_q.push_front(w);
      void'(dict_q.pop_back());
    end
  endtask

  // Next expected line: a full 128 bits, or the zero-padded remainder of a flush.
  task automatic next_expected(output logic [127:0] d, output bit last);
    d = '0;
    last = (exp_bits.size() < 128);
    for (int b = 0; b < 128 && exp_bits.size() > 0; b++) d[b] = exp_bits.pop_front();
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    bus.i_word  = 32'h0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic send_word(input logic [31:0] w, input bit rand_ready);
    bit took;
    took = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_word  = w;
    for (int n = 0; n < 300 && !took; n++) begin
      if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus.o_ready;
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    if (took) model_accept(w);
    else begin
      checks++; failures++;
      $display("FAIL send_word_timeout word=%h o_ready=%b required=1", w, bus.o_ready);
    end
  endtask

  task automatic pulse_flush();
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    bus.i_ready = 1'b1;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = !bus.o_busy && !bus.o_valid;
      @(posedge clk);
      #1;
    end
    if (!idle) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout o_busy=%b o_valid=%b required=0/0", bus.o_busy, bus.o_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_data !== 128'h0) begin failures++; $display("FAIL reset_o_data got=%h exp=0", bus.o_data); end
    checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL reset_o_last got=%b exp=0", bus.o_last); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_o_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_basic();
    logic [127:0] ed, gd;
    bit el, gl;
    do_reset();
    bus.i_ready = 1'b1;
    send_word(32'h12345678, 1'b0);
    send_word(32'h12345678, 1'b0);
    pulse_flush();
    wait_idle();
    checks++;
    if (got_data.size() != 1) begin
      failures++; $display("FAIL basic_lines got=%0d exp=1", got_data.size());
    end else begin
      gd = got_data[0];
      checks++;
      if (gd !== 128'h8_48D1_59E1 || got_last[0] !== 1'b1) begin
        failures++; $display("FAIL basic_line got=%h last=%0d exp=%h last=1", gd, got_last[0], 128'h8_48D1_59E1);
      end
    end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL basic_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL basic_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_partial_codes();
    logic [127:0] ed, gd;
    bit el, gl;
    do_reset();
    bus.i_ready = 1'b1;
    send_word(32'h12345678, 1'b0);
    send_word(32'h1234ABCD, 1'b0);
    send_word(32'h123456AA, 1'b0);
    send_word(32'h000000FF, 1'b0);
    pulse_flush();
    wait_idle();
    checks++;
    if (got_data.size() != 1) begin
      failures++; $display("FAIL partial_lines got=%0d exp=1", got_data.size());
    end else begin
      gd = got_data[0];
      checks++; if (gd[57:34] !== 24'hABCD03) begin failures++; $display("FAIL partial_mmxx got=%h exp=%h", gd[57:34], 24'hABCD03); end
      checks++; if (gd[73:58] !== 16'hAA1B) begin failures++; $display("FAIL partial_mmmx got=%h exp=%h", gd[73:58], 16'hAA1B); end
      checks++; if (gd[85:74] !== 12'hFF7) begin failures++; $display("FAIL partial_zzzx got=%h exp=%h", gd[85:74], 12'hFF7); end
      checks++; if (gd[127:86] !== 42'h0) begin failures++; $display("FAIL partial_pad got=%h exp=0", gd[127:86]); end
    end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL partial_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL partial_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_zeros();
    logic [127:0] gd;
    do_reset();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 64; i++) send_word(32'h0, 1'b0);
    wait_idle();
    checks++;
    if (got_data.size() != 1) begin
      failures++; $display("FAIL zeros_lines got=%0d exp=1", got_data.size());
    end else begin
      gd = got_data[0];
      checks++;
      if (gd !== 128'h0 || got_last[0] !== 1'b0) begin
        failures++; $display("FAIL zeros_line got=%h last=%0d exp=0 last=0", gd, got_last[0]);
      end
    end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL zeros_busy got=%b exp=0", bus.o_busy); end
    got_data.delete(); got_last.delete(); exp_bits.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] w[20];
    logic [127:0] ed, gd;
    bit el, gl, r;
    int n_acc, first_drop;
    do_reset();
    for (int i = 0; i < 20; i++) w[i] = {8'h80 | 8'(i), 24'($urandom)};
    bus.i_ready = 1'b0;
    n_acc = 0; first_drop = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.i_valid = (n_acc < 20);
      if (n_acc < 20) bus.i_word = w[n_acc];
      @(negedge clk);
      r = bus.o_ready;
      if (!r && first_drop < 0) first_drop = n_acc;
      @(posedge clk);
      #1;
      if (r && n_acc < 20) begin
        model_accept(w[n_acc]);
        n_acc++;
      end
    end
    bus.i_valid = 1'b0;
    checks++; if (first_drop != 4) begin failures++; $display("FAIL bp_first_drop got=%0d exp=4", first_drop); end
    checks++; if (n_acc != 8) begin failures++; $display("FAIL bp_held_words got=%0d exp=8", n_acc); end
    checks++; if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
      failures++; $display("FAIL bp_stall got ready=%b valid=%b exp ready=0 valid=1", bus.o_ready, bus.o_valid);
    end
    bus.i_ready = 1'b1;
    for (int i = n_acc; i < 20; i++) send_word(w[i], 1'b0);
    pulse_flush();
    wait_idle();
    checks++; if (got_data.size() != 6) begin failures++; $display("FAIL bp_lines got=%0d exp=6", got_data.size()); end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL bp_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_eviction();
    logic [31:0] w[17];
    logic [767:0] stream;
    logic [127:0] ed, gd;
    bit el, gl;
    do_reset();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 17; i++) w[i] = {8'h40 | 8'(i), 24'($urandom)};
    for (int i = 0; i < 17; i++) send_word(w[i], 1'b0);
    send_word(w[16], 1'b0);
    send_word(w[0], 1'b0);
    pulse_flush();
    wait_idle();
    checks++;
    if (got_data.size() != 5) begin
      failures++; $display("FAIL evict_lines got=%0d exp=5", got_data.size());
    end else begin
      stream = '0;
      for (int k = 0; k < 5; k++) stream[k*128 +: 128] = got_data[k];
      checks++; if (stream[583:578] !== 6'b000010) begin failures++; $display("FAIL evict_mmmm got=%b exp=000010", stream[583:578]); end
      checks++; if (stream[617:584] !== {w[0], 2'b01}) begin failures++; $display("FAIL evict_xxxx got=%h exp=%h", stream[617:584], {w[0], 2'b01}); end
    end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL evict_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL evict_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_flush_with_word();
    logic [127:0] ed, gd;
    bit el, gl, r;
    do_reset();
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_word  = 32'hCAFEBABE;
    bus.i_flush = 1'b1;
    @(negedge clk);
    r = bus.o_ready;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    if (r) model_accept(32'hCAFEBABE);
    wait_idle();
    checks++; if (got_data.size() != 1) begin failures++; $display("FAIL flushword_lines got=%0d exp=1", got_data.size()); end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL flushword_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL flushword_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_reset_midline();
    logic [31:0] w[6];
    logic [127:0] ed, gd;
    bit el, gl;
    do_reset();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = {8'h20 | 8'(i), 24'($urandom)};
    for (int i = 0; i < 6; i++) send_word(w[i], 1'b0);
    send_word(32'h00000011, 1'b0);
    send_word(32'h00000022, 1'b0);
    checks++; if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1) begin
      failures++; $display("FAIL midrst_pre got valid=%b busy=%b exp 1/1", bus.o_valid, bus.o_busy);
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_in_reset got=%b exp=0", bus.o_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_data !== 128'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", bus.o_data); end
    checks++; if (bus.o_last !== 1'b0) begin failures++; $display("FAIL midrst_last got=%b exp=0", bus.o_last); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", bus.o_ready); end
    bus.i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pulse_flush();
    wait_idle();
    checks++; if (got_data.size() != 0) begin failures++; $display("FAIL midrst_no_line got=%0d exp=0", got_data.size()); end
    got_data.delete(); got_last.delete();
    // Dictionary must be empty again: this word is coded as a literal.
    send_word(w[0], 1'b0);
    pulse_flush();
    wait_idle();
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL midrst_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL midrst_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  task automatic test_random();
    logic [31:0] hist[$];
    logic [31:0] base, w;
    logic [127:0] ed, gd;
    bit el, gl;
    int choice;
    do_reset();
    bus.i_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      choice = (hist.size() == 0) ? 5 : $urandom_range(0, 5);
      base = (hist.size() == 0) ? 32'h0 : hist[$urandom_range(0, hist.size() - 1)];
      case (choice)
        0:       w = 32'h0;
        1:       w = base;
        2:       w = $urandom & 32'hFF;
        3:       w = {base[31:8], 8'($urandom)};
        4:       w = {base[31:16], 16'($urandom)};
        default: w = $urandom;
      endcase
      send_word(w, 1'b1);
      hist.push_back(w);
      if (hist.size() > 20) void'(hist.pop_front());
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    pulse_flush();
    wait_idle();
    checks++; if (got_data.size() == 0) begin failures++; $display("FAIL random_lines got=0 exp>0"); end
    while (got_data.size() > 0) begin
      next_expected(ed, el);
      gd = got_data.pop_front(); gl = got_last.pop_front();
      checks++;
      if (gd !== ed || gl !== el) begin failures++; $display("FAIL random_model got=%h last=%0d exp=%h last=%0d", gd, gl, ed, el); end
    end
    checks++; if (exp_bits.size() != 0) begin failures++; $display("FAIL random_leftover got=%0d exp=0", exp_bits.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_codes();
    test_zeros();
    test_backpressure();
    test_eviction();
    test_flush_with_word();
    test_reset_midline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/compressor.md
# compressor

Word-level dictionary compressor: the encode side of the `decompressor` datapath. It accepts one 32-bit word per cycle over a valid/ready handshake. Each word is matched against a 16-entry FIFO dictionary and encoded as a variable-length code of 2–34 bits. The codes are packed LSB-first into 128-bit output lines in the exact bit format the decompressor unpacks.

## Interface
- WIDTH, 32: input word width.
- WORD, 16: dictionary entries.
- WIDTH_DATA_OUT, 128: output line width.
- LENGTH, 6: code-length field width (maximum code length 34).
- FILL_WIDTH, 8: accumulator fill-count width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, synchronous and active-high.
- i_valid  in  1  i_word is valid.
- i_word  in  32  uncompressed word.
- o_ready  out  1  word accepted on an edge where i_valid && o_ready.
- i_flush  in  1  single-cycle pulse: emit the partial line, zero-padded.
- o_valid  out  1  o_data holds a line.
- i_ready  in  1  downstream accepts the line on an edge where o_valid && i_ready.
- o_data  out  128  packed line; first code at bit 0.
- o_last  out  1  line was produced by a flush.
- o_busy  out  1  fill != 0, or a flush is pending.

## Operation
- Encoding: codes are LSB-first. Bits [1:0] are the code; for code 2'b11, bits [3:2] are the backup code.
  - zzzz: word == 0. Code 00, length 2.
  - mmmm: full match at dictionary index i. Code 10, idx in [5:2], length 6.
  - zzzx: word[31:8] == 0. Code 11 with backup 01, word[7:0] in [11:4], length 12.
  - mmmx: word[31:8] matches entry i. Code 11 with backup 10, idx in [7:4], word[7:0] in [15:8], length 16.
  - mmxx: word[31:16] matches entry i. Code 11 with backup 00, idx in [7:4], word[15:0] in [23:8], length 24.
  - xxxx: no other case applies. Code 01, word in [33:2], length 34.
- Priority: zzzz > mmmm > zzzx > mmmx > mmxx > xxxx. When several entries match, the lowest index wins.
- Dictionary: 16×32 shift FIFO; newest entry at index 0; all entries reset to 0.
  - The accepted word is pushed only for xxxx, mmxx and mmmx. Entry k moves to k+1 and entry 15 is dropped.
  - Matching uses the dictionary contents before the push.
  - Flush does not clear the dictionary.
- Accumulator: 162 bits, with a fill count.
  - Pop condition: fill >= 128 and (!o_valid || i_ready).
  - On pop: o_data <= acc[127:0], the accumulator shifts right 128, fill -= 128, o_valid <= 1, o_last <= 0.
  - Append on accept: code << (fill, minus 128 if popping this edge) is ORed in, and fill increases by the code length. Pop and append occur on the same edge.
- o_ready = (fill < 128) && !flush_pending && !i_reset.
- Flush: i_flush sets flush_pending. Any word accepted on the same edge is appended first.
  - When fill < 128 and (!o_valid || i_ready), a padded line is emitted: acc[127:0] with upper bits zero, o_last = 1, fill <= 0, flush_pending cleared.
  - If fill == 0 the flush completes with no line emitted.
  - While fill >= 128, normal pops continue first.
- o_valid clears on an edge where o_valid && i_ready && no new pop or flush line is produced.
- o_data and o_last are stable while o_valid && !i_ready.

## Timing
- Reset values: o_valid=0, o_data=0, o_last=0, o_busy=0, fill=0, acc=0, flush_pending=0, dictionary all zero. o_ready=1 in the cycle after reset deasserts.
- Word accepted at edge T: its bits are in the accumulator after T. The earliest line containing them has o_valid high after edge T+1.
- Throughput: one word per cycle while fill < 128.
- Reset asserted mid-line clears all state; partial data is discarded and no line is emitted.
- Simultaneous accept, pop and i_ready are legal and must not lose or duplicate bits.

## Test plan
- Reset; send 0x12345678, then 0x12345678, then flush. Expect one line with [1:0]=01, [33:2]=0x12345678, [35:34]=10, [39:36]=0, rest 0, and o_last=1.
- After 0x12345678, send 0x1234ABCD, 0x123456AA, 0x000000FF. Expect codes mmxx (idx 0, 0xABCD, 24b), mmmx (idx 1, 0xAA, 16b), zzzx (0xFF, 12b) at bit offsets 34, 58, 74.
- Send 64 zero words. Expect exactly one all-zero line, o_last=0, fill 0 afterwards.
- Hold i_ready=0 and stream 20 distinct xxxx words. Expect o_ready to drop at fill >= 128. Then release i_ready; the lines must carry all 680 bits in order with no gaps.
- Send 17 distinct xxxx words, then resend word #1. Expect xxxx (evicted), not mmmm; resending word #17 yields mmmm idx 0.
- Assert reset with fill=100 and o_valid=1. Expect all outputs at reset values next cycle and no flushed line.
